// File: rtl/lif_pkg.sv
// lif_pkg: shared types and constants for the LIF spike monitor.
//   fsm_e          monitor FSM states (IDLE, RUN)
//   SEL_*          readout select codes for dout
//   ST_*_OFS       status byte bit positions, counted down from the MSB
package lif_pkg;

  localparam int W_DEF     = 8;
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  localparam int SEL_RATE   = 0;
  localparam int SEL_ISI    = 1;
  localparam int SEL_PEAK   = 2;
  localparam int SEL_STATUS = 3;

  // status byte = {rate_sat, isi_sat, armed, running, zeros}
  localparam int ST_RATE_SAT_OFS = 0;
  localparam int ST_ISI_SAT_OFS  = 1;
  localparam int ST_ARMED_OFS    = 2;
  localparam int ST_RUN_OFS      = 3;

endpackage

// File: rtl/lif_sat_counter.sv
// lif_sat_counter: up-counter that sticks at 2**W-1 and remembers that an
// increment was clipped.
//   clk, reset_n   clock, synchronous active-low reset
//   inc            count up by one (ignored while at full scale, sets sat)
//   clr            force count and sat to 0 (highest priority)
//   load1          force count to 1 and sat to 0
//   q              current count
//   sat            sticky: an increment was dropped since the last clr/load1
module lif_sat_counter
  import lif_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (load1) begin
      cnt_d = {{(W-1){1'b0}}, 1'b1};
      sat_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == {W{1'b1}}) sat_d = 1'b1;
      else                    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign q   = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: measures spike rate per window, last inter-spike
// interval and peak membrane state of a LIF neuron, with one readout mux.
//   clk, reset_n   clock, synchronous active-low reset
//   en             1 = measure, 0 = idle (partial window discarded)
//   spike_in       spike from the neuron; rising edge counts once
//   state_in       membrane state, unsigned
//   win_len        window length in cycles, 0 = 2**W
//   sel            readout select: rate / ISI / peak / status
//   dout           selected result register
//   win_done       pulse: rate/peak registers load at the end of this cycle
//   isi_valid      pulse: ISI register loads at the end of this cycle
//
// state | meaning
// IDLE  | not measuring; window, ISI counter and arming held clear
// RUN   | counting cycles, edges and peak; windows run back to back
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic [W-1:0]     state_in,
  input  logic [W-1:0]     win_len,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout,
  output logic             win_done,
  output logic             isi_valid
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] FULL = {W{1'b1}};

  fsm_e         fsm_q, fsm_d;
  logic         spike_q;
  logic [W-1:0] win_cnt_q, win_cnt_d;
  logic [W-1:0] cur_peak_q, cur_peak_d;
  logic         armed_q, armed_d;
  logic [W-1:0] rate_q, rate_d;
  logic [W-1:0] isi_q, isi_d;
  logic [W-1:0] peak_q, peak_d;
  logic         rate_sat_q, rate_sat_d;
  logic         isi_sat_q, isi_sat_d;

  logic         run;
  logic         spike_edge;
  logic         win_last;
  logic         win_end;
  logic         isi_fire;
  logic [W-1:0] cur_cnt;
  logic         rate_sat_cur;
  logic [W-1:0] isi_cnt;
  logic         isi_sat_cur;
  logic         rate_clip;
  logic [W-1:0] rate_next;
  logic [W-1:0] peak_max;
  logic [W-1:0] status;

  assign run        = (fsm_q == RUN);
  assign spike_edge = spike_in & ~spike_q;

  // A shortened win_len that win_cnt has already passed is caught by the
  // full-scale compare, so a window never exceeds 2**W cycles.
  assign win_last = (win_cnt_q == (win_len - ONE)) || (win_cnt_q == FULL);
  // Dropping en discards the partial window, even on its last cycle.
  assign win_end  = run & en & win_last;
  assign isi_fire = run & spike_edge & armed_q;

  assign rate_clip = spike_edge & (cur_cnt == FULL);
  assign rate_next = rate_clip ? cur_cnt : cur_cnt + {{(W-1){1'b0}}, spike_edge};
  assign peak_max  = (state_in > cur_peak_q) ? state_in : cur_peak_q;

  lif_sat_counter #(.W(W)) u_cur_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (run & spike_edge),
    .clr     (~run | ~en | win_end),
    .load1   (1'b0),
    .q       (cur_cnt),
    .sat     (rate_sat_cur)
  );

  lif_sat_counter #(.W(W)) u_isi_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (run),
    .clr     (~run | ~en),
    .load1   (run & spike_edge),
    .q       (isi_cnt),
    .sat     (isi_sat_cur)
  );

  always_comb begin
    fsm_d      = fsm_q;
    win_cnt_d  = win_cnt_q;
    cur_peak_d = cur_peak_q;
    armed_d    = armed_q;
    rate_d     = rate_q;
    isi_d      = isi_q;
    peak_d     = peak_q;
    rate_sat_d = rate_sat_q;
    isi_sat_d  = isi_sat_q;

    case (fsm_q)
      IDLE: if (en)  fsm_d = RUN;
      RUN:  if (!en) fsm_d = IDLE;
      default:       fsm_d = IDLE;
    endcase

    if (!run || !en) begin
      win_cnt_d  = '0;
      cur_peak_d = '0;
      armed_d    = 1'b0;
    end else if (win_end) begin
      win_cnt_d  = '0;
      cur_peak_d = '0;
      rate_d     = rate_next;
      rate_sat_d = rate_sat_cur | rate_clip;
      peak_d     = peak_max;
    end else begin
      win_cnt_d  = win_cnt_q + ONE;
      cur_peak_d = peak_max;
    end

    if (run && en && spike_edge) armed_d = 1'b1;

    // An edge on the cycle en falls still reports its interval.
    if (isi_fire) begin
      isi_d     = isi_cnt;
      isi_sat_d = isi_sat_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q      <= IDLE;
      spike_q    <= 1'b0;
      win_cnt_q  <= '0;
      cur_peak_q <= '0;
      armed_q    <= 1'b0;
      rate_q     <= '0;
      isi_q      <= '0;
      peak_q     <= '0;
      rate_sat_q <= 1'b0;
      isi_sat_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      spike_q    <= spike_in;
      win_cnt_q  <= win_cnt_d;
      cur_peak_q <= cur_peak_d;
      armed_q    <= armed_d;
      rate_q     <= rate_d;
      isi_q      <= isi_d;
      peak_q     <= peak_d;
      rate_sat_q <= rate_sat_d;
      isi_sat_q  <= isi_sat_d;
    end
  end

  always_comb begin
    status = '0;
    status[W-1-ST_RATE_SAT_OFS] = rate_sat_q;
    status[W-1-ST_ISI_SAT_OFS]  = isi_sat_q;
    status[W-1-ST_ARMED_OFS]    = armed_q;
    status[W-1-ST_RUN_OFS]      = run;
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_W'(SEL_RATE):   dout = rate_q;
      SEL_W'(SEL_ISI):    dout = isi_q;
      SEL_W'(SEL_PEAK):   dout = peak_q;
      SEL_W'(SEL_STATUS): dout = status;
      default:            dout = '0;
    endcase
  end

  // Strobes are suppressed in a reset cycle: the loads they announce never happen.
  assign win_done  = reset_n & win_end;
  assign isi_valid = reset_n & isi_fire;

endmodule

// File: tb/tb_lif_spike_monitor.sv
module tb_lif_spike_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] state_in = '0;
  logic [7:0] win_len = 8'd10;
  logic [1:0] sel = '0;
  logic [7:0] dout;
  logic       win_done;
  logic       isi_valid;

  always #5 clk = ~clk;

  lif_spike_monitor #(.W(8), .SEL_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .spike_in  (spike_in),
    .state_in  (state_in),
    .win_len   (win_len),
    .sel       (sel),
    .dout      (dout),
    .win_done  (win_done),
    .isi_valid (isi_valid)
  );

  typedef struct {
    logic [7:0] dout;
    bit         wd;
    bit         iv;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  string phase = "reset";
  int   tb_cyc = 0;

  // Reference model: time-stamped edges and plain integer counts.
  bit m_run = 0, m_prev = 0, m_armed = 0;
  int m_pos = 0, m_cnt = 0, m_peak = 0, m_last = 0, m_cycle = 0;
  int m_rate = 0, m_isi = 0, m_peak_reg = 0;
  bit m_rate_sat = 0, m_isi_sat = 0;

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_cycle();
    exp_t e;
    bit   edge_b;
    bit   last;
    int   wl_eff;
    int   d;
    edge_b = spike_in && !m_prev;
    e.wd  = 0;
    e.iv  = 0;
    e.tag = phase;
    case (sel)
      2'd0:    e.dout = 8'(m_rate);
      2'd1:    e.dout = 8'(m_isi);
      2'd2:    e.dout = 8'(m_peak_reg);
      default: e.dout = {m_rate_sat, m_isi_sat, m_armed, m_run, 4'b0000};
    endcase
    if (!reset_n) begin
      sb.push_back(e);
      m_run = 0; m_prev = 0; m_armed = 0; m_pos = 0; m_cnt = 0; m_peak = 0;
      m_rate = 0; m_isi = 0; m_peak_reg = 0; m_rate_sat = 0; m_isi_sat = 0;
      m_cycle++;
      return;
    end
    if (m_run) begin
      wl_eff = (win_len == 0) ? 256 : int'(win_len);
      last   = (m_pos == wl_eff - 1) || (m_pos == 255);
      if (edge_b) m_cnt++;
      if (int'(state_in) > m_peak) m_peak = int'(state_in);
      if (edge_b) begin
        if (m_armed) begin
          d = m_cycle - m_last;
          e.iv = 1;
          m_isi = min255(d);
          m_isi_sat = (d > 255);
        end
        m_armed = 1;
        m_last  = m_cycle;
      end
      if (!en) begin
        m_run = 0; m_pos = 0; m_cnt = 0; m_peak = 0; m_armed = 0;
      end else if (last) begin
        e.wd = 1;
        m_rate = min255(m_cnt);
        m_rate_sat = (m_cnt > 255);
        m_peak_reg = m_peak;
        m_pos = 0; m_cnt = 0; m_peak = 0;
      end else begin
        m_pos++;
      end
    end else if (en) begin
      m_run = 1; m_pos = 0; m_cnt = 0; m_peak = 0; m_armed = 0;
    end
    m_prev = spike_in;
    m_cycle++;
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input bit e, input bit s, input int st, input int wl,
                      input int sl);
    @(posedge clk);
    #1;
    reset_n  = r;
    en       = e;
    spike_in = s;
    state_in = 8'(st);
    win_len  = 8'(wl);
    sel      = 2'(sl);
    tb_cyc++;
    model_cycle();
  endtask

  task automatic chk(input string name, input int act, input int exp_v, input string tag);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s [%s] t=%0t got=%0d expected=%0d", name, tag, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout", int'(dout), int'(e.dout), e.tag);
        chk("win_done", int'(win_done), int'(e.wd), e.tag);
        chk("isi_valid", int'(isi_valid), int'(e.iv), e.tag);
      end
    end
  end

  initial begin : stim
    int wl;
    bit e_r;
    // reset and idle
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 10, i % 4);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 10, 3);

    // rate over a 10-cycle window, then a held spike
    phase = "rate_win10";
    step(1, 1, 0, 0, 10, 3);
    for (int c = 0; c < 22; c++)
      step(1, 1, (c == 2 || c == 5 || c == 9 || (c >= 12 && c <= 15)), 7, 10, tb_cyc % 4);

    // ISI: edges at RUN cycles 3, 10, 40
    phase = "isi";
    step(1, 0, 0, 0, 50, 1);
    step(1, 1, 0, 0, 50, 1);
    for (int c = 0; c < 46; c++)
      step(1, 1, (c == 3 || c == 10 || c == 40), 1, 50, (c % 2 == 0) ? 1 : 3);

    // 256-cycle window with a spike every second cycle, then a long gap
    phase = "win256";
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 262; c++) step(1, 1, (c % 2 == 1), 3, 0, tb_cyc % 4);
    phase = "isi_sat";
    for (int c = 0; c < 300; c++) step(1, 1, 0, 3, 0, (c % 2 == 0) ? 1 : 3);
    step(1, 1, 1, 3, 0, 1);
    for (int c = 0; c < 4; c++) step(1, 1, 0, 3, 0, (c % 2 == 0) ? 1 : 3);

    // peak over a 20-cycle window
    phase = "peak";
    step(1, 0, 0, 0, 20, 2);
    step(1, 1, 0, 0, 20, 2);
    for (int c = 0; c < 20; c++) step(1, 1, 0, (c <= 10) ? c * 20 : 50, 20, 2);
    for (int c = 0; c < 24; c++) step(1, 1, (c % 5 == 0), 30 + c, 20, c % 4);

    // en dropped mid-window, then re-enabled
    phase = "en_drop";
    step(1, 0, 0, 0, 10, 3);
    step(1, 1, 0, 0, 10, 3);
    for (int c = 0; c < 6; c++) step(1, 1, (c == 1), 9, 10, tb_cyc % 4);
    step(1, 0, 1, 9, 10, 3);
    for (int c = 0; c < 4; c++) step(1, 0, 0, 9, 10, c);
    step(1, 1, 0, 0, 10, 3);
    for (int c = 0; c < 12; c++) step(1, 1, (c == 2 || c == 6), 4, 10, 3 - (c % 4));

    // reset mid-window
    phase = "reset_mid";
    step(1, 0, 0, 0, 10, 0);
    step(1, 1, 0, 0, 10, 0);
    for (int c = 0; c < 5; c++) step(1, 1, (c == 1), 100, 10, 3);
    step(0, 1, 0, 100, 10, 3);
    for (int c = 0; c < 4; c++) step(1, 0, 0, 0, 10, c);

    // random traffic, win_len changed at random points
    phase = "random";
    wl  = 5;
    e_r = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) wl = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      if ($urandom_range(0, 199) == 0) e_r = ~e_r;
      else if (!e_r && $urandom_range(0, 9) == 0) e_r = 1;
      step(($urandom_range(0, 599) != 0), e_r, ($urandom_range(0, 9) < 4),
           int'($urandom_range(0, 255)), wl, int'($urandom_range(0, 3)));
    end

    phase = "drain";
    step(1, 0, 0, 0, 10, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain got=%0d expected=0 pending entries", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
